// File: rtl/rc4_key_search_core.sv
// rc4_key_search_core: brute-force RC4 key search engine.
// For each candidate key (key_base, key_base+KEY_STRIDE, ... up to key_limit)
// it runs the KSA, decrypts the encrypted ROM into the decrypted RAM with the
// PRGA, and accepts the key when every byte is lowercase a-z or space.
// All memories are synchronous: a read costs one wait state between driving
// the address and consuming the data.
// Optional build macro RC4_EARLY_ABORT_EN: abandon a candidate at its first
// non-plaintext byte instead of decrypting the whole message.
module rc4_key_search_core #(
    parameter int KEY_BYTES  = 3,
    parameter int MSG_LEN    = 32,
    parameter int KEY_STRIDE = 1,
    localparam int KEY_BITS  = 8 * KEY_BYTES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_base,
    input  logic [KEY_BITS-1:0] key_limit,
    output logic [7:0]          s_addr,
    output logic [7:0]          s_wdata,
    output logic                s_wren,
    input  logic [7:0]          s_rdata,
    output logic [7:0]          e_addr,
    input  logic [7:0]          e_rdata,
    output logic [7:0]          d_addr,
    output logic [7:0]          d_wdata,
    output logic                d_wren,
    output logic [KEY_BITS-1:0] secret_key,
    output logic                busy,
    output logic                found,
    output logic                not_found
);

    typedef enum logic [4:0] {
        ST_IDLE, ST_INIT,
        ST_K_RI, ST_K_WI, ST_K_GI, ST_K_WJ, ST_K_GJ, ST_K_SW,
        ST_P_RI, ST_P_WI, ST_P_GI, ST_P_WJ, ST_P_GJ, ST_P_SW,
        ST_P_RF, ST_P_WF, ST_P_GF,
        ST_CHECK, ST_NEXT, ST_FOUND, ST_EXHAUSTED
    } state_t;

    state_t              state_q;
    logic [7:0]          i_q, j_q, k_q, kidx_q, si_q, sj_q;
    logic [KEY_BITS-1:0] key_q, lim_q;
    logic                ok_q;
    logic [7:0]          s_addr_q, s_wdata_q, e_addr_q, d_addr_q, d_wdata_q;
    logic                s_wren_q, d_wren_q, busy_q, found_q, nf_q;

    logic [7:0]          kbyte_d, j_ksa_d, j_prga_d, dbyte_d;
    logic                byte_ok_d;
    logic [KEY_BITS:0]   next_key_d;

    function automatic logic is_plain(input logic [7:0] b);
        return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7A));
    endfunction

    // Key byte for the current KSA index (byte 0 is the most significant).
    always_comb begin
        kbyte_d = 8'h00;
        for (int n = 0; n < KEY_BYTES; n++) begin
            if (kidx_q == 8'(n)) kbyte_d = key_q[KEY_BITS-1-8*n -: 8];
        end
    end

    // Datapath helpers: j updates, decrypted byte, next candidate with carry bit.
    always_comb begin
        j_ksa_d    = j_q + s_rdata + kbyte_d;
        j_prga_d   = j_q + s_rdata;
        dbyte_d    = s_rdata ^ e_rdata;
        byte_ok_d  = is_plain(dbyte_d);
        next_key_d = {1'b0, key_q} + (KEY_BITS+1)'(KEY_STRIDE);
    end

    // Search FSM with registered memory ports and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            i_q       <= 8'h00;
            j_q       <= 8'h00;
            k_q       <= 8'h00;
            kidx_q    <= 8'h00;
            si_q      <= 8'h00;
            sj_q      <= 8'h00;
            key_q     <= '0;
            lim_q     <= '0;
            ok_q      <= 1'b0;
            s_addr_q  <= 8'h00;
            s_wdata_q <= 8'h00;
            s_wren_q  <= 1'b0;
            e_addr_q  <= 8'h00;
            d_addr_q  <= 8'h00;
            d_wdata_q <= 8'h00;
            d_wren_q  <= 1'b0;
            busy_q    <= 1'b0;
            found_q   <= 1'b0;
            nf_q      <= 1'b0;
        end else begin
            s_wren_q <= 1'b0;
            d_wren_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        key_q <= key_base;
                        lim_q <= key_limit;
                        i_q   <= 8'h00;
                        ok_q  <= 1'b1;
                        if (key_base > key_limit) begin
                            nf_q    <= 1'b1;
                            state_q <= ST_EXHAUSTED;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= ST_INIT;
                        end
                    end
                end
                ST_INIT: begin
                    s_addr_q  <= i_q;
                    s_wdata_q <= i_q;
                    s_wren_q  <= 1'b1;
                    i_q       <= i_q + 8'd1;
                    if (i_q == 8'hFF) begin
                        j_q     <= 8'h00;
                        kidx_q  <= 8'h00;
                        state_q <= ST_K_RI;
                    end
                end
                ST_K_RI: begin
                    s_addr_q <= i_q;
                    state_q  <= ST_K_WI;
                end
                ST_K_WI: state_q <= ST_K_GI;
                ST_K_GI: begin
                    si_q     <= s_rdata;
                    j_q      <= j_ksa_d;
                    s_addr_q <= j_ksa_d;
                    state_q  <= ST_K_WJ;
                end
                ST_K_WJ: state_q <= ST_K_GJ;
                ST_K_GJ: begin
                    s_addr_q  <= i_q;
                    s_wdata_q <= s_rdata;
                    s_wren_q  <= 1'b1;
                    state_q   <= ST_K_SW;
                end
                ST_K_SW: begin
                    s_addr_q  <= j_q;
                    s_wdata_q <= si_q;
                    s_wren_q  <= 1'b1;
                    i_q       <= i_q + 8'd1;
                    kidx_q    <= (kidx_q == 8'(KEY_BYTES-1)) ? 8'h00 : kidx_q + 8'd1;
                    if (i_q == 8'hFF) begin
                        j_q     <= 8'h00;
                        k_q     <= 8'h00;
                        state_q <= ST_P_RI;
                    end else begin
                        state_q <= ST_K_RI;
                    end
                end
                ST_P_RI: begin
                    i_q      <= i_q + 8'd1;
                    s_addr_q <= i_q + 8'd1;
                    state_q  <= ST_P_WI;
                end
                ST_P_WI: state_q <= ST_P_GI;
                ST_P_GI: begin
                    si_q     <= s_rdata;
                    j_q      <= j_prga_d;
                    s_addr_q <= j_prga_d;
                    state_q  <= ST_P_WJ;
                end
                ST_P_WJ: state_q <= ST_P_GJ;
                ST_P_GJ: begin
                    sj_q      <= s_rdata;
                    s_addr_q  <= i_q;
                    s_wdata_q <= s_rdata;
                    s_wren_q  <= 1'b1;
                    state_q   <= ST_P_SW;
                end
                ST_P_SW: begin
                    s_addr_q  <= j_q;
                    s_wdata_q <= si_q;
                    s_wren_q  <= 1'b1;
                    state_q   <= ST_P_RF;
                end
                ST_P_RF: begin
                    // Swap only exchanges values, so si+sj still indexes f.
                    s_addr_q <= si_q + sj_q;
                    e_addr_q <= k_q;
                    state_q  <= ST_P_WF;
                end
                ST_P_WF: state_q <= ST_P_GF;
                ST_P_GF: begin
                    d_addr_q  <= k_q;
                    d_wdata_q <= dbyte_d;
                    d_wren_q  <= 1'b1;
                    k_q       <= k_q + 8'd1;
                    if (!byte_ok_d) ok_q <= 1'b0;
`ifdef RC4_EARLY_ABORT_EN
                    if (!byte_ok_d)                     state_q <= ST_NEXT;
                    else if (k_q == 8'(MSG_LEN-1))      state_q <= ST_CHECK;
                    else                                state_q <= ST_P_RI;
`else
                    if (k_q == 8'(MSG_LEN-1))           state_q <= ST_CHECK;
                    else                                state_q <= ST_P_RI;
`endif
                end
                ST_CHECK: begin
                    if (ok_q) begin
                        found_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_FOUND;
                    end else begin
                        state_q <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    // Carry out of the key width counts as past the limit.
                    if (next_key_d[KEY_BITS] || (next_key_d[KEY_BITS-1:0] > lim_q)) begin
                        nf_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_EXHAUSTED;
                    end else begin
                        key_q   <= next_key_d[KEY_BITS-1:0];
                        i_q     <= 8'h00;
                        ok_q    <= 1'b1;
                        state_q <= ST_INIT;
                    end
                end
                ST_FOUND:     state_q <= ST_FOUND;
                ST_EXHAUSTED: state_q <= ST_EXHAUSTED;
                default:      state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_addr     = s_addr_q;
    assign s_wdata    = s_wdata_q;
    assign s_wren     = s_wren_q;
    assign e_addr     = e_addr_q;
    assign d_addr     = d_addr_q;
    assign d_wdata    = d_wdata_q;
    assign d_wren     = d_wren_q;
    assign secret_key = key_q;
    assign busy       = busy_q;
    assign found      = found_q;
    assign not_found  = nf_q;

endmodule

// File: tb/tb_rc4_key_search_core.sv
// Bench for rc4_key_search_core: three instances (3-byte key stride 1,
// 3-byte key stride 4, 2-byte key stride 1), each with its own synchronous
// S-RAM, encrypted ROM and decrypted RAM models. Expected outcomes are queued
// when a search is launched and compared when the core reports completion.
module tb_rc4_key_search_core;

    localparam int KEY_CYC = 2082;  // cycles per fully decrypted candidate

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start   [3];
    logic [23:0] kbase   [3];
    logic [23:0] klim    [3];
    logic [7:0]  s_addr  [3];
    logic [7:0]  s_wdata [3];
    logic [7:0]  s_rdata [3];
    logic [7:0]  e_addr  [3];
    logic [7:0]  e_rdata [3];
    logic [7:0]  d_addr  [3];
    logic [7:0]  d_wdata [3];
    logic        s_wren  [3];
    logic        d_wren  [3];
    logic        busy    [3];
    logic        found   [3];
    logic        nf      [3];
    logic [23:0] skey0, skey1;
    logic [15:0] skey2;

    logic [7:0]  smem [3][256];
    logic [7:0]  emem [3][256];
    logic [7:0]  dmem [3][256];

    int    checks = 0;
    int    errors = 0;
    string pt = "the quick brown fox jumps over t";
    logic  both_hi = 1'b0;

    typedef struct {
        logic        fnd;
        logic [23:0] key;
    } exp_t;
    exp_t       sb_q[$];
    logic [7:0] pt_q[$];

    rc4_key_search_core #(.KEY_BYTES(3), .MSG_LEN(32), .KEY_STRIDE(1)) u_dut0 (
        .clk(clk), .reset(reset), .start(start[0]),
        .key_base(kbase[0]), .key_limit(klim[0]),
        .s_addr(s_addr[0]), .s_wdata(s_wdata[0]), .s_wren(s_wren[0]), .s_rdata(s_rdata[0]),
        .e_addr(e_addr[0]), .e_rdata(e_rdata[0]),
        .d_addr(d_addr[0]), .d_wdata(d_wdata[0]), .d_wren(d_wren[0]),
        .secret_key(skey0), .busy(busy[0]), .found(found[0]), .not_found(nf[0])
    );

    rc4_key_search_core #(.KEY_BYTES(3), .MSG_LEN(32), .KEY_STRIDE(4)) u_dut1 (
        .clk(clk), .reset(reset), .start(start[1]),
        .key_base(kbase[1]), .key_limit(klim[1]),
        .s_addr(s_addr[1]), .s_wdata(s_wdata[1]), .s_wren(s_wren[1]), .s_rdata(s_rdata[1]),
        .e_addr(e_addr[1]), .e_rdata(e_rdata[1]),
        .d_addr(d_addr[1]), .d_wdata(d_wdata[1]), .d_wren(d_wren[1]),
        .secret_key(skey1), .busy(busy[1]), .found(found[1]), .not_found(nf[1])
    );

    rc4_key_search_core #(.KEY_BYTES(2), .MSG_LEN(32), .KEY_STRIDE(1)) u_dut2 (
        .clk(clk), .reset(reset), .start(start[2]),
        .key_base(kbase[2][15:0]), .key_limit(klim[2][15:0]),
        .s_addr(s_addr[2]), .s_wdata(s_wdata[2]), .s_wren(s_wren[2]), .s_rdata(s_rdata[2]),
        .e_addr(e_addr[2]), .e_rdata(e_rdata[2]),
        .d_addr(d_addr[2]), .d_wdata(d_wdata[2]), .d_wren(d_wren[2]),
        .secret_key(skey2), .busy(busy[2]), .found(found[2]), .not_found(nf[2])
    );

    // Synchronous memories: data for an address appears one cycle later.
    always @(posedge clk) begin
        for (int n = 0; n < 3; n++) begin
            if (s_wren[n]) smem[n][s_addr[n]] <= s_wdata[n];
            s_rdata[n] <= smem[n][s_addr[n]];
            e_rdata[n] <= emem[n][e_addr[n]];
            if (d_wren[n]) dmem[n][d_addr[n]] <= d_wdata[n];
            if (found[n] && nf[n]) both_hi <= 1'b1;
        end
    end

    function automatic logic [23:0] get_key(input int n);
        case (n)
            0:       return skey0;
            1:       return skey1;
            default: return {8'h00, skey2};
        endcase
    endfunction

    // Software RC4: encrypt the plaintext under key (kb bytes) into ROM n.
    task automatic rc4_fill(input int n, input logic [23:0] key, input int kb);
        logic [7:0] s [256];
        logic [7:0] ii, jj, t, kbyte, f;
        for (int x = 0; x < 256; x++) s[x] = x[7:0];
        jj = 8'h00;
        for (int x = 0; x < 256; x++) begin
            kbyte = key[8*(kb-1-(x % kb)) +: 8];
            jj = jj + s[x] + kbyte;
            t = s[x]; s[x] = s[jj]; s[jj] = t;
        end
        ii = 8'h00;
        jj = 8'h00;
        for (int k = 0; k < 256; k++) emem[n][k] = 8'h00;
        for (int k = 0; k < 32; k++) begin
            ii = ii + 8'd1;
            jj = jj + s[ii];
            t = s[ii]; s[ii] = s[jj]; s[jj] = t;
            t = s[ii] + s[jj];
            f = s[t];
            emem[n][k] = f ^ pt.getc(k);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int n = 0; n < 3; n++) start[n] = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Launch one search, optionally pulse start again mid-run, then score it.
    task automatic run_search(input string name, input int n, input logic [23:0] base,
                              input logic [23:0] lim, input logic efnd,
                              input logic [23:0] ekey, input int poke, output int cyc);
        exp_t e;
        kbase[n] = base;
        klim[n]  = lim;
        e.fnd = efnd;
        e.key = ekey;
        sb_q.push_back(e);
        @(negedge clk);
        start[n] = 1'b1;
        @(posedge clk);
        #1 start[n] = 1'b0;
        cyc = 0;
        while (!(found[n] || nf[n]) && cyc < 5 * KEY_CYC) begin
            if (poke >= 0 && cyc == poke) begin
                kbase[n] = 24'h000008;
                start[n] = 1'b1;
            end else begin
                start[n] = 1'b0;
            end
            @(posedge clk);
            #1 cyc++;
        end
        start[n] = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (!(found[n] || nf[n])) begin
            errors++;
            $display("FAIL %s_timeout: no completion after %0d cycles, required found or not_found", name, cyc);
        end else begin
            checks++;
            if (found[n] !== e.fnd) begin
                errors++;
                $display("FAIL %s_found: got %b required %b", name, found[n], e.fnd);
            end
            checks++;
            if (nf[n] !== !e.fnd) begin
                errors++;
                $display("FAIL %s_not_found: got %b required %b", name, nf[n], !e.fnd);
            end
            checks++;
            if (get_key(n) !== e.key) begin
                errors++;
                $display("FAIL %s_key: got %h required %h", name, get_key(n), e.key);
            end
            checks++;
            if (busy[n] !== 1'b0) begin
                errors++;
                $display("FAIL %s_busy: got %b required 0", name, busy[n]);
            end
        end
    endtask

    task automatic check_plain(input string name, input int n);
        logic [7:0] want;
        for (int k = 0; k < 32; k++) begin
            want = pt_q.pop_front();
            checks++;
            if (dmem[n][k] !== want) begin
                errors++;
                $display("FAIL %s_d%0d: got %h required %h", name, k, dmem[n][k], want);
            end
        end
    endtask

    task automatic test_reset();
        logic act;
        reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            start[n] = 1'b0;
            kbase[n] = 24'h0;
            klim[n]  = 24'h0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        act = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            for (int n = 0; n < 3; n++) if (s_wren[n] || d_wren[n]) act = 1'b1;
        end
        for (int n = 0; n < 3; n++) begin
            checks++;
            if ({busy[n], found[n], nf[n], s_wren[n], d_wren[n]} !== 5'b0 || get_key(n) !== 24'h0 ||
                s_addr[n] !== 8'h0 || s_wdata[n] !== 8'h0 || e_addr[n] !== 8'h0 ||
                d_addr[n] !== 8'h0 || d_wdata[n] !== 8'h0) begin
                errors++;
                $display("FAIL reset_outputs%0d: busy=%b found=%b nf=%b key=%h saddr=%h required all 0",
                         n, busy[n], found[n], nf[n], get_key(n), s_addr[n]);
            end
        end
        checks++;
        if (act !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_writes: got activity %b required 0", act);
        end
    endtask

    task automatic test_known_key();
        int cyc;
        do_reset();
        for (int k = 0; k < 32; k++) pt_q.push_back(pt.getc(k));
        run_search("known", 0, 24'h000000, 24'h00000F, 1'b1, 24'h000003, 100, cyc);
        check_plain("known", 0);
    endtask

    task automatic test_exhaust();
        int cyc;
        do_reset();
        run_search("exhaust", 0, 24'h000004, 24'h000006, 1'b0, 24'h000006, -1, cyc);
        do_reset();
        run_search("base_gt_limit", 0, 24'h000005, 24'h000004, 1'b0, 24'h000005, -1, cyc);
        checks++;
        if (cyc !== 0) begin
            errors++;
            $display("FAIL base_gt_limit_cycles: got %0d required 0", cyc);
        end
    endtask

    task automatic test_stride();
        int cyc;
        do_reset();
        run_search("stride_b1", 1, 24'h000001, 24'h00000F, 1'b0, 24'h00000D, -1, cyc);
        checks++;
`ifdef RC4_EARLY_ABORT_EN
        if (!(cyc < 4 * KEY_CYC)) begin
            errors++;
            $display("FAIL abort_cycles: got %0d required below %0d", cyc, 4 * KEY_CYC);
        end
`else
        if (cyc !== 4 * KEY_CYC) begin
            errors++;
            $display("FAIL full_cycles: got %0d required %0d", cyc, 4 * KEY_CYC);
        end
`endif
        do_reset();
        run_search("stride_b3", 1, 24'h000003, 24'h00000F, 1'b1, 24'h000003, -1, cyc);
        checks++;
        if (cyc !== KEY_CYC - 1) begin
            errors++;
            $display("FAIL stride_b3_cycles: got %0d required %0d", cyc, KEY_CYC - 1);
        end
    endtask

    task automatic test_midrun_reset();
        int cyc;
        do_reset();
        kbase[0] = 24'h000000;
        klim[0]  = 24'h00000F;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        cyc = 0;
        while (skey0 !== 24'h000001 && cyc < 2 * KEY_CYC) begin
            @(posedge clk);
            #1 cyc++;
        end
        repeat (1795) @(posedge clk);
        #1;
        checks++;
        if (skey0 !== 24'h000001 || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL midrun_state: key=%h busy=%b required key 000001 busy 1", skey0, busy[0]);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({busy[0], found[0], nf[0], s_wren[0], d_wren[0]} !== 5'b0 || skey0 !== 24'h0 ||
            s_addr[0] !== 8'h0 || e_addr[0] !== 8'h0 || d_addr[0] !== 8'h0) begin
            errors++;
            $display("FAIL midrun_reset_outputs: busy=%b found=%b nf=%b key=%h required all 0",
                     busy[0], found[0], nf[0], skey0);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        run_search("restart", 0, 24'h000000, 24'h00000F, 1'b1, 24'h000003, -1, cyc);
    endtask

    task automatic test_two_byte_key();
        int cyc;
        do_reset();
        for (int k = 0; k < 32; k++) pt_q.push_back(pt.getc(k));
        run_search("kb2_found", 2, 24'h00FFFE, 24'h00FFFF, 1'b1, 24'h00FFFF, -1, cyc);
        check_plain("kb2", 2);
        do_reset();
        run_search("kb2_miss", 2, 24'h00FFFE, 24'h00FFFE, 1'b0, 24'h00FFFE, -1, cyc);
    endtask

    initial begin
        reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            start[n] = 1'b0;
            kbase[n] = 24'h0;
            klim[n]  = 24'h0;
        end
        rc4_fill(0, 24'h000003, 3);
        rc4_fill(1, 24'h000003, 3);
        rc4_fill(2, 24'h00FFFF, 2);
        test_reset();
        test_known_key();
        test_exhaust();
        test_stride();
        test_midrun_reset();
        test_two_byte_key();
        checks++;
        if (both_hi !== 1'b0) begin
            errors++;
            $display("FAIL exclusive_status: found and not_found seen together %b required 0", both_hi);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
